// File: rtl/regfile_sb_if.sv
// Register-file bus: write port, two read ports, reservation port and status.
interface regfile_sb_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
) ();

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_busy1;
   logic              rd_busy2;

   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rsv_ok;

   logic [ADDR_W:0]   busy_cnt;
   logic              err_unrsv;

   // Requester side (pipeline issue/writeback logic)
   modport master (
      output wr_en, wr_addr, wr_data,
      output rd_addr1, rd_addr2,
      output rsv_en, rsv_addr,
      input  rd_data1, rd_data2, rd_busy1, rd_busy2,
      input  rsv_ok, busy_cnt, err_unrsv
   );

   // Register-file side
   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  rd_addr1, rd_addr2,
      input  rsv_en, rsv_addr,
      output rd_data1, rd_data2, rd_busy1, rd_busy2,
      output rsv_ok, busy_cnt, err_unrsv
   );

endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard (busy bits), two combinational
// read ports, one write port and a reservation port for pending producers.
module regfile_sb #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 3,
   parameter bit          BYPASS  = 1'b1,
   parameter bit          ZERO_R0 = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   regfile_sb_if.slave   bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [CNT_W-1:0]  busy_cnt_q;
   logic [CNT_W-1:0]  busy_cnt_d;
   logic              err_q;
   logic              err_d;

   logic              wr_r0_c;
   logic              wr_eff_c;
   logic              rsv_r0_c;
   logic              rsv_ok_c;
   logic              rsv_acc_c;
   logic              fwd1_c;
   logic              fwd2_c;
   logic [DATA_W-1:0] rd_data1_c;
   logic [DATA_W-1:0] rd_data2_c;
   logic              rd_busy1_c;
   logic              rd_busy2_c;

   // Register 0 exemption and effective write qualification
   always_comb begin
      wr_r0_c  = ZERO_R0 && (bus.wr_addr == '0);
      rsv_r0_c = ZERO_R0 && (bus.rsv_addr == '0);
      wr_eff_c = bus.wr_en && !wr_r0_c;
   end

   // Same-cycle forwarding detection per read port
   always_comb begin
      fwd1_c = BYPASS && bus.wr_en && (bus.wr_addr == bus.rd_addr1);
      fwd2_c = BYPASS && bus.wr_en && (bus.wr_addr == bus.rd_addr2);
   end

   // Read port 1: zero register, forwarded write data, or stored word
   always_comb begin
      rd_data1_c = regs_q[bus.rd_addr1];
      rd_busy1_c = busy_q[bus.rd_addr1] && !fwd1_c;
      if (fwd1_c) begin
         rd_data1_c = bus.wr_data;
      end
      if (ZERO_R0 && (bus.rd_addr1 == '0)) begin
         rd_data1_c = '0;
         rd_busy1_c = 1'b0;
      end
   end

   // Read port 2: identical structure to port 1
   always_comb begin
      rd_data2_c = regs_q[bus.rd_addr2];
      rd_busy2_c = busy_q[bus.rd_addr2] && !fwd2_c;
      if (fwd2_c) begin
         rd_data2_c = bus.wr_data;
      end
      if (ZERO_R0 && (bus.rd_addr2 == '0)) begin
         rd_data2_c = '0;
         rd_busy2_c = 1'b0;
      end
   end

   // Reservation accepted if the target is free or is being retired this cycle
   always_comb begin
      rsv_ok_c = !busy_q[bus.rsv_addr] ||
                 (bus.wr_en && (bus.wr_addr == bus.rsv_addr));
      if (rsv_r0_c) begin
         rsv_ok_c = 1'b0;
      end
      rsv_acc_c = bus.rsv_en && rsv_ok_c;
   end

   // Next storage contents
   always_comb begin
      regs_d = regs_q;
      if (wr_eff_c) begin
         regs_d[bus.wr_addr] = bus.wr_data;
      end
   end

   // Next busy vector: write clears, accepted reservation sets (set wins)
   always_comb begin
      busy_d = busy_q;
      if (wr_eff_c) begin
         busy_d[bus.wr_addr] = 1'b0;
      end
      if (rsv_acc_c) begin
         busy_d[bus.rsv_addr] = 1'b1;
      end
   end

   // Population count of the next busy vector
   always_comb begin
      busy_cnt_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
      end
   end

   // Sticky error: a write retired a register nobody had reserved
   always_comb begin
      err_d = err_q;
      if (wr_eff_c && !busy_q[bus.wr_addr]) begin
         err_d = 1'b1;
      end
   end

   // State registers; reset discards all data and pending reservations
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         err_q      <= err_d;
      end
   end

   // Output drive
   assign bus.rd_data1  = rd_data1_c;
   assign bus.rd_data2  = rd_data2_c;
   assign bus.rd_busy1  = rd_busy1_c;
   assign bus.rd_busy2  = rd_busy2_c;
   assign bus.rsv_ok    = rsv_ok_c;
   assign bus.busy_cnt  = busy_cnt_q;
   assign bus.err_unrsv = err_q;

endmodule
